// File: rtl/display_mode_fsm.sv
// display_mode_fsm: synchronised, debounced next/prev buttons step a wrapping display-mode index.
// Define DISPLAY_MODE_AUTOREPEAT_EN to make held buttons auto-repeat after HOLD_CYCLES / REPEAT_CYCLES.
module display_mode_fsm #(
  parameter int NUM_MODES       = 4,
  parameter int RESET_MODE      = 0,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 12_500_000,
  localparam int MODE_W         = $clog2(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 next_bt,
  input  logic                 prev_bt,
  output logic [MODE_W-1:0]    mode_sel,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 mode_changed
);

  if (NUM_MODES < 2 || NUM_MODES > 16 || RESET_MODE < 0 || RESET_MODE >= NUM_MODES ||
      DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("display_mode_fsm: illegal parameter combination");
  end

  localparam int                   DB_W          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]      DB_LAST       = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MODE_W-1:0]    MODE_LAST     = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0]    RESET_SEL     = MODE_W'(RESET_MODE);
  localparam logic [MODE_W:0]      NUM_MODES_EXT = (MODE_W + 1)'(NUM_MODES);
  localparam logic [NUM_MODES-1:0] ONE_HOT_BASE  = NUM_MODES'(1);
  localparam logic [NUM_MODES-1:0] RESET_ONEHOT  = ONE_HOT_BASE << RESET_MODE;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  // Bit 0 tracks next_bt, bit 1 tracks prev_bt throughout.
  logic [1:0]      sync1, sync2;
  db_state_t       state [2];
  db_state_t       state_nx [2];
  logic [DB_W-1:0] cnt [2];
  logic [DB_W-1:0] cnt_nx [2];
  logic [1:0]      press_evt, press_evt_nx;

`ifdef DISPLAY_MODE_AUTOREPEAT_EN
  localparam int              HOLD_W     = $clog2((HOLD_CYCLES > REPEAT_CYCLES ?
                                                   HOLD_CYCLES : REPEAT_CYCLES) + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt [2];
  logic [HOLD_W-1:0] hold_nx [2];
  logic [1:0]        repeating, repeating_nx;
`endif

  logic [MODE_W-1:0]    mode_nx;
  logic [NUM_MODES-1:0] onehot_nx;
  logic                 changed_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      press_evt <= '0;
      for (int b = 0; b < 2; b++) begin
        state[b] <= RELEASED;
        cnt[b]   <= '0;
      end
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
      repeating <= '0;
      for (int b = 0; b < 2; b++) hold_cnt[b] <= '0;
`endif
    end else begin
      sync1     <= {prev_bt, next_bt};
      sync2     <= sync1;
      press_evt <= press_evt_nx;
      for (int b = 0; b < 2; b++) begin
        state[b] <= state_nx[b];
        cnt[b]   <= cnt_nx[b];
      end
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
      repeating <= repeating_nx;
      for (int b = 0; b < 2; b++) hold_cnt[b] <= hold_nx[b];
`endif
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES further stable samples.
  always_comb begin
    press_evt_nx = '0;
    for (int b = 0; b < 2; b++) begin
      state_nx[b] = state[b];
      cnt_nx[b]   = cnt[b];
    end
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
    repeating_nx = repeating;
    for (int b = 0; b < 2; b++) hold_nx[b] = hold_cnt[b];
`endif
    for (int b = 0; b < 2; b++) begin
      unique case (state[b])
        RELEASED: begin
          cnt_nx[b] = '0;
          if (sync2[b]) state_nx[b] = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!sync2[b]) begin
            state_nx[b] = RELEASED;
            cnt_nx[b]   = '0;
          end else if (cnt[b] == DB_LAST) begin
            state_nx[b]     = HELD;
            cnt_nx[b]       = '0;
            press_evt_nx[b] = 1'b1;
          end else begin
            cnt_nx[b] = cnt[b] + DB_W'(1);
          end
        end
        HELD: begin
          cnt_nx[b] = '0;
          if (!sync2[b]) begin
            state_nx[b] = RELEASE_WAIT;
          end
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
          // First repeat after HOLD_CYCLES held samples, then every REPEAT_CYCLES.
          else if (hold_cnt[b] == (repeating[b] ? REP_LAST : HOLD_LAST)) begin
            hold_nx[b]      = '0;
            repeating_nx[b] = 1'b1;
            press_evt_nx[b] = 1'b1;
          end else begin
            hold_nx[b] = hold_cnt[b] + HOLD_W'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (sync2[b]) begin
            state_nx[b] = HELD;
            cnt_nx[b]   = '0;
          end else if (cnt[b] == DB_LAST) begin
            state_nx[b] = RELEASED;
            cnt_nx[b]   = '0;
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
            hold_nx[b]      = '0;
            repeating_nx[b] = 1'b0;
`endif
          end else begin
            cnt_nx[b] = cnt[b] + DB_W'(1);
          end
        end
        default: begin
          state_nx[b] = RELEASED;
          cnt_nx[b]   = '0;
        end
      endcase
    end
  end

  // Opposing events in the same cycle cancel; an out-of-range index recovers silently.
  always_comb begin
    mode_nx    = mode_sel;
    changed_nx = 1'b0;
    if ({1'b0, mode_sel} >= NUM_MODES_EXT) begin
      mode_nx = RESET_SEL;
    end else if (press_evt == 2'b01) begin
      mode_nx    = (mode_sel == MODE_LAST) ? '0 : mode_sel + MODE_W'(1);
      changed_nx = 1'b1;
    end else if (press_evt == 2'b10) begin
      mode_nx    = (mode_sel == '0) ? MODE_LAST : mode_sel - MODE_W'(1);
      changed_nx = 1'b1;
    end
    onehot_nx = ONE_HOT_BASE << mode_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_sel     <= RESET_SEL;
      mode_onehot  <= RESET_ONEHOT;
      mode_changed <= 1'b0;
    end else begin
      mode_sel     <= mode_nx;
      mode_onehot  <= onehot_nx;
      mode_changed <= changed_nx;
    end
  end

endmodule

// File: tb/tb_display_mode_fsm.sv
// Bench for display_mode_fsm: phase table, hand-written corner sequences and a random run,
// all checked cycle by cycle against a run-length debounce model.
module tb_display_mode_fsm;

  localparam int NM   = 3;
  localparam int DB   = 4;
  localparam int RM   = 0;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  localparam int MW   = $clog2(NM);

  logic          clk = 1'b0;
  logic          reset;
  logic          next_bt;
  logic          prev_bt;
  logic [MW-1:0] mode_sel;
  logic [NM-1:0] mode_onehot;
  logic          mode_changed;

  display_mode_fsm #(
    .NUM_MODES(NM),
    .RESET_MODE(RM),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .next_bt(next_bt),
    .prev_bt(prev_bt),
    .mode_sel(mode_sel),
    .mode_onehot(mode_onehot),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt;
  int first_pulse;

  // Model: a button's debounced state flips once the two-cycle-delayed raw level has
  // disagreed with it for DB+1 consecutive samples; a 0->1 flip is a press event.
  int       m_mode;
  bit       m_changed;
  bit [1:0] raw_d1, raw_d2;
  bit [1:0] deb;
  bit [1:0] ev_pend;
  int       run [2];
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
  int       held [2];
`endif

  task automatic modelEdge(input bit rst, input bit [1:0] raw);
    bit [1:0] lvl;
    bit [1:0] ev;
    if (rst) begin
      m_mode    = RM;
      m_changed = 1'b0;
      raw_d1    = '0;
      raw_d2    = '0;
      deb       = '0;
      ev_pend   = '0;
      for (int b = 0; b < 2; b++) begin
        run[b] = 0;
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
        held[b] = 0;
`endif
      end
    end else begin
      m_changed = 1'b0;
      if (ev_pend == 2'b01) begin
        m_mode    = (m_mode + 1) % NM;
        m_changed = 1'b1;
      end else if (ev_pend == 2'b10) begin
        m_mode    = (m_mode + NM - 1) % NM;
        m_changed = 1'b1;
      end
      lvl    = raw_d2;
      raw_d2 = raw_d1;
      raw_d1 = raw;
      ev     = '0;
      for (int b = 0; b < 2; b++) begin
        if (lvl[b] != deb[b]) begin
          run[b]++;
          if (run[b] == DB + 1) begin
            deb[b] = lvl[b];
            run[b] = 0;
            if (deb[b]) ev[b] = 1'b1;
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
            else held[b] = 0;
`endif
          end
        end else begin
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
          if (deb[b] && run[b] == 0) begin
            held[b]++;
            if (held[b] == HOLD || (held[b] > HOLD && (held[b] - HOLD) % REP == 0))
              ev[b] = 1'b1;
          end
`endif
          run[b] = 0;
        end
      end
      ev_pend = ev;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    logic [NM-1:0] exp_oh;
    exp_oh = NM'(1) << m_mode;
    checkOutput("mode_sel", int'(mode_sel), m_mode);
    checkOutput("mode_onehot", int'(mode_onehot), int'(exp_oh));
    checkOutput("mode_changed", int'(mode_changed), int'(m_changed));
  endtask

  // Holds the inputs for n clock edges, checking every cycle and tallying pulses.
  task automatic applyStimulus(input bit rst, input bit nx, input bit pv, input int n);
    pulse_cnt   = 0;
    first_pulse = -1;
    for (int i = 0; i < n; i++) begin
      reset   = rst;
      next_bt = nx;
      prev_bt = pv;
      @(posedge clk);
      modelEdge(rst, {pv, nx});
      #1;
      checkModel();
      if (mode_changed) begin
        if (first_pulse < 0) first_pulse = i;
        pulse_cnt++;
      end
    end
  endtask

  typedef struct {
    bit rst;
    bit nx;
    bit pv;
    int cycles;
    int exp_mode;
    int exp_pulses;
    int exp_first;
  } vec_t;

  vec_t vecs [19];

  initial begin
    reset   = 1'b1;
    next_bt = 1'b0;
    prev_bt = 1'b0;

    vecs[0]  = '{1, 0, 0, 2,  0, 0, -1};
    vecs[1]  = '{0, 0, 0, 5,  0, 0, -1};
    vecs[2]  = '{0, 1, 0, 10, 1, 1, 7};
    vecs[3]  = '{0, 0, 0, 10, 1, 0, -1};
    vecs[4]  = '{0, 1, 0, 10, 2, 1, 7};
    vecs[5]  = '{0, 0, 0, 10, 2, 0, -1};
    vecs[6]  = '{0, 1, 0, 10, 0, 1, 7};
    vecs[7]  = '{0, 0, 0, 10, 0, 0, -1};
    vecs[8]  = '{0, 0, 1, 10, 2, 1, 7};
    vecs[9]  = '{0, 0, 0, 10, 2, 0, -1};
    vecs[10] = '{0, 1, 0, 3,  2, 0, -1};
    vecs[11] = '{0, 0, 0, 10, 2, 0, -1};
    vecs[12] = '{0, 1, 1, 10, 2, 0, -1};
    vecs[13] = '{0, 0, 0, 10, 2, 0, -1};
    vecs[14] = '{0, 1, 0, 4,  2, 0, -1};
    vecs[15] = '{0, 0, 0, 10, 2, 0, -1};
    vecs[16] = '{0, 0, 1, 10, 1, 1, 7};
    vecs[17] = '{0, 0, 0, 10, 1, 0, -1};
    vecs[18] = '{1, 0, 0, 1,  0, 0, -1};

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].nx, vecs[i].pv, vecs[i].cycles);
      checkOutput($sformatf("row%0d mode", i), int'(mode_sel), vecs[i].exp_mode);
      checkOutput($sformatf("row%0d onehot", i), int'(mode_onehot), 1 << vecs[i].exp_mode);
      checkOutput($sformatf("row%0d pulses", i), pulse_cnt, vecs[i].exp_pulses);
      checkOutput($sformatf("row%0d first pulse", i), first_pulse, vecs[i].exp_first);
    end

    // Step to mode 1, then reset while next_bt is still being debounced.
    applyStimulus(0, 1, 0, 10);
    applyStimulus(0, 0, 0, 10);
    checkOutput("pre-reset mode", int'(mode_sel), 1);
    applyStimulus(0, 1, 0, 2);
    applyStimulus(1, 1, 0, 1);
    checkOutput("mid-reset mode", int'(mode_sel), RM);
    applyStimulus(0, 1, 0, 10);
    checkOutput("post-reset first pulse", first_pulse, 7);
    checkOutput("post-reset pulses", pulse_cnt, 1);
    checkOutput("post-reset mode", int'(mode_sel), 1);
    applyStimulus(0, 0, 0, 12);

    // Long hold: repeats only when auto-repeat is built in.
    applyStimulus(0, 1, 0, 28);
`ifdef DISPLAY_MODE_AUTOREPEAT_EN
    checkOutput("long hold pulses", pulse_cnt, 4);
`else
    checkOutput("long hold pulses", pulse_cnt, 1);
`endif
    checkOutput("long hold mode", int'(mode_sel), 2);
    applyStimulus(0, 0, 0, 12);

    for (int s = 0; s < 250; s++) begin
      bit rst;
      bit nx;
      bit pv;
      rst = ($urandom_range(0, 39) == 0);
      nx  = ($urandom_range(0, 2) == 0);
      pv  = ($urandom_range(0, 3) == 0);
      applyStimulus(rst, nx, pv, $urandom_range(1, 14));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
